// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : morse_pkg
//  Description : Shared state encoding, Morse unit lengths, ASCII ranges and
//                the ROM code word layout for the Morse keyer.
//  Revision    : 1.0  initial release
// ============================================================================
package morse_pkg;

   // Keyer sequencing states
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_MARK     = 3'd1,
      S_ELEM_GAP = 3'd2,
      S_CHAR_GAP = 3'd3,
      S_WORD_GAP = 3'd4
   } state_t;

   // Durations in Morse time units
   localparam logic [2:0] DOT      = 3'd1;
   localparam logic [2:0] DASH     = 3'd3;
   localparam logic [2:0] ELEM_GAP = 3'd1;
   localparam logic [2:0] CHAR_GAP = 3'd3;
   localparam logic [2:0] WORD_GAP = 3'd4;

   // ASCII ranges of the supported character set
   localparam logic [7:0] ASCII_SPACE       = 8'h20;
   localparam logic [7:0] ASCII_DIGIT_0     = 8'h30;
   localparam logic [7:0] ASCII_DIGIT_9     = 8'h39;
   localparam logic [7:0] ASCII_UPPER_A     = 8'h41;
   localparam logic [7:0] ASCII_UPPER_Z     = 8'h5A;
   localparam logic [7:0] ASCII_LOWER_A     = 8'h61;
   localparam logic [7:0] ASCII_LOWER_Z     = 8'h7A;
   localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

   // ROM word: pattern is left-aligned, bit 4 is the first element, 1 = dash
   typedef struct packed {
      logic       valid;
      logic [2:0] len;
      logic [4:0] pattern;
   } code_t;

endpackage
`default_nettype wire

// File: rtl/morse_rom.sv
`default_nettype none
// ============================================================================
//  Module      : morse_rom
//  Description : Combinational ASCII to ITU Morse lookup. Lower case is folded
//                to upper case; space is valid with zero elements.
//  Revision    : 1.0  initial release
// ============================================================================
module morse_rom
   import morse_pkg::*;
(
   input  logic [7:0] i_char,
   output code_t      o_code
);

   logic [7:0] folded;

   // Fold a-z onto A-Z so one table serves both cases
   always_comb begin
      folded = i_char;
      if (i_char >= ASCII_LOWER_A && i_char <= ASCII_LOWER_Z)
         folded = i_char - ASCII_CASE_OFFSET;
   end

   // Range check for validity, table lookup for length and element pattern
   always_comb begin
      o_code.valid   = (folded >= ASCII_UPPER_A && folded <= ASCII_UPPER_Z) ||
                       (folded >= ASCII_DIGIT_0 && folded <= ASCII_DIGIT_9) ||
                       (folded == ASCII_SPACE);
      o_code.len     = 3'd0;
      o_code.pattern = 5'b00000;
      case (folded)
         8'h41: {o_code.len, o_code.pattern} = {3'd2, 5'b01000}; // A .-
         8'h42: {o_code.len, o_code.pattern} = {3'd4, 5'b10000}; // B -...
         8'h43: {o_code.len, o_code.pattern} = {3'd4, 5'b10100}; // C -.-.
         8'h44: {o_code.len, o_code.pattern} = {3'd3, 5'b10000}; // D -..
         8'h45: {o_code.len, o_code.pattern} = {3'd1, 5'b00000}; // E .
         8'h46: {o_code.len, o_code.pattern} = {3'd4, 5'b00100}; // F ..-.
         8'h47: {o_code.len, o_code.pattern} = {3'd3, 5'b11000}; // G --.
         8'h48: {o_code.len, o_code.pattern} = {3'd4, 5'b00000}; // H ....
         8'h49: {o_code.len, o_code.pattern} = {3'd2, 5'b00000}; // I ..
         8'h4A: {o_code.len, o_code.pattern} = {3'd4, 5'b01110}; // J .---
         8'h4B: {o_code.len, o_code.pattern} = {3'd3, 5'b10100}; // K -.-
         8'h4C: {o_code.len, o_code.pattern} = {3'd4, 5'b01000}; // L .-..
         8'h4D: {o_code.len, o_code.pattern} = {3'd2, 5'b11000}; // M --
         8'h4E: {o_code.len, o_code.pattern} = {3'd2, 5'b10000}; // N -.
         8'h4F: {o_code.len, o_code.pattern} = {3'd3, 5'b11100}; // O ---
         8'h50: {o_code.len, o_code.pattern} = {3'd4, 5'b01100}; // P .--.
         8'h51: {o_code.len, o_code.pattern} = {3'd4, 5'b11010}; // Q --.-
         8'h52: {o_code.len, o_code.pattern} = {3'd3, 5'b01000}; // R .-.
         8'h53: {o_code.len, o_code.pattern} = {3'd3, 5'b00000}; // S ...
         8'h54: {o_code.len, o_code.pattern} = {3'd1, 5'b10000}; // T -
         8'h55: {o_code.len, o_code.pattern} = {3'd3, 5'b00100}; // U ..-
         8'h56: {o_code.len, o_code.pattern} = {3'd4, 5'b00010}; // V ...-
         8'h57: {o_code.len, o_code.pattern} = {3'd3, 5'b01100}; // W .--
         8'h58: {o_code.len, o_code.pattern} = {3'd4, 5'b10010}; // X -..-
         8'h59: {o_code.len, o_code.pattern} = {3'd4, 5'b10110}; // Y -.--
         8'h5A: {o_code.len, o_code.pattern} = {3'd4, 5'b11000}; // Z --..
         8'h30: {o_code.len, o_code.pattern} = {3'd5, 5'b11111}; // 0 -----
         8'h31: {o_code.len, o_code.pattern} = {3'd5, 5'b01111}; // 1 .----
         8'h32: {o_code.len, o_code.pattern} = {3'd5, 5'b00111}; // 2 ..---
         8'h33: {o_code.len, o_code.pattern} = {3'd5, 5'b00011}; // 3 ...--
         8'h34: {o_code.len, o_code.pattern} = {3'd5, 5'b00001}; // 4 ....-
         8'h35: {o_code.len, o_code.pattern} = {3'd5, 5'b00000}; // 5 .....
         8'h36: {o_code.len, o_code.pattern} = {3'd5, 5'b10000}; // 6 -....
         8'h37: {o_code.len, o_code.pattern} = {3'd5, 5'b11000}; // 7 --...
         8'h38: {o_code.len, o_code.pattern} = {3'd5, 5'b11100}; // 8 ---..
         8'h39: {o_code.len, o_code.pattern} = {3'd5, 5'b11110}; // 9 ----.
         default: {o_code.len, o_code.pattern} = {3'd0, 5'b00000};
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/morse_keyer.sv
`default_nettype none
// ============================================================================
//  Module      : morse_keyer
//  Description : Accepts ASCII characters on a valid/ready handshake and keys
//                them out as ITU Morse with unit-accurate mark/gap timing.
//  Revision    : 1.0  initial release
// ============================================================================
module morse_keyer
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 6250000
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic [7:0] iCHAR,
   input  logic       iVALID,
   output logic       oREADY,
   output logic       oKEY,
   output logic       oBUSY,
   output logic       oERR
);

   localparam int                UNIT_W    = $clog2(UNIT_CYCLES + 1);
   localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);

   code_t             rom_code;
   state_t            state_q,    state_d;
   logic [UNIT_W-1:0] unit_cnt_q, unit_cnt_d;
   logic [2:0]        dur_cnt_q,  dur_cnt_d;
   logic [2:0]        len_q,      len_d;
   logic [4:0]        pat_q,      pat_d;
   logic              key_q,      key_d;
   logic              busy_q,     busy_d;
   logic              err_q,      err_d;
   logic              ready_q,    ready_d;
   logic              accept;
   logic              unit_done;
   logic              state_done;
   logic [2:0]        dur_last;

   morse_rom u_rom (
      .i_char (iCHAR),
      .o_code (rom_code)
   );

   // Last unit index of the current state; a mark's length follows the head element
   always_comb begin
      case (state_q)
         S_MARK:     dur_last = pat_q[4] ? (DASH - 3'd1) : (DOT - 3'd1);
         S_ELEM_GAP: dur_last = ELEM_GAP - 3'd1;
         S_CHAR_GAP: dur_last = CHAR_GAP - 3'd1;
         S_WORD_GAP: dur_last = WORD_GAP - 3'd1;
         default:    dur_last = 3'd0;
      endcase
   end

   assign accept     = (state_q == S_IDLE) && ready_q && iVALID;
   assign unit_done  = (unit_cnt_q == UNIT_LAST);
   assign state_done = unit_done && (dur_cnt_q == dur_last);

   // Next-state, element sequencing and timing counters; outputs follow state_d
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      pat_d   = pat_q;
      err_d   = 1'b0;

      // Counters restart on every state entry and stay at zero in IDLE
      if (state_q == S_IDLE || state_done) begin
         unit_cnt_d = '0;
         dur_cnt_d  = 3'd0;
      end else if (unit_done) begin
         unit_cnt_d = '0;
         dur_cnt_d  = dur_cnt_q + 3'd1;
      end else begin
         unit_cnt_d = unit_cnt_q + UNIT_W'(1);
         dur_cnt_d  = dur_cnt_q;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (!rom_code.valid) begin
                  err_d = 1'b1;
               end else if (rom_code.len == 3'd0) begin
                  state_d = S_WORD_GAP;
               end else begin
                  state_d = S_MARK;
                  len_d   = rom_code.len;
                  pat_d   = rom_code.pattern;
               end
            end
         end
         S_MARK: begin
            if (state_done) begin
               len_d   = len_q - 3'd1;
               pat_d   = {pat_q[3:0], 1'b0};
               state_d = (len_q == 3'd1) ? S_CHAR_GAP : S_ELEM_GAP;
            end
         end
         S_ELEM_GAP: if (state_done) state_d = S_MARK;
         S_CHAR_GAP: if (state_done) state_d = S_IDLE;
         S_WORD_GAP: if (state_done) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase

      key_d   = (state_d == S_MARK);
      busy_d  = (state_d != S_IDLE);
      // Ready drops for the cycle after any accept, including a rejected one
      ready_d = (state_d == S_IDLE) && !accept;
   end

   // State and registered outputs; reset clears everything immediately
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q    <= S_IDLE;
         unit_cnt_q <= '0;
         dur_cnt_q  <= 3'd0;
         len_q      <= 3'd0;
         pat_q      <= 5'b00000;
         key_q      <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         unit_cnt_q <= unit_cnt_d;
         dur_cnt_q  <= dur_cnt_d;
         len_q      <= len_d;
         pat_q      <= pat_d;
         key_q      <= key_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         ready_q    <= ready_d;
      end
   end

   assign oREADY = ready_q;
   assign oKEY   = key_q;
   assign oBUSY  = busy_q;
   assign oERR   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_morse_keyer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morse_keyer
//  Description : Self-checking bench for morse_keyer with UNIT_CYCLES = 4.
//                Per-cycle {key,busy,err,ready} is checked against a model
//                built from Morse code strings and unit durations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_morse_keyer;

   localparam int U = 4;

   logic       iCLK;
   logic       iRST_N;
   logic [7:0] iCHAR;
   logic       iVALID;
   logic       oREADY;
   logic       oKEY;
   logic       oBUSY;
   logic       oERR;

   int compared   = 0;
   int mismatched = 0;

   logic [3:0] obs[$];
   logic [3:0] exp_q[$];

   string morse_tab [36] = '{
      ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
      "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
      "..-", "...-", ".--", "-..-", "-.--", "--..",
      "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
      "---..", "----."
   };

   morse_keyer #(.UNIT_CYCLES(U)) dut (
      .iCLK   (iCLK),
      .iRST_N (iRST_N),
      .iCHAR  (iCHAR),
      .iVALID (iVALID),
      .oREADY (oREADY),
      .oKEY   (oKEY),
      .oBUSY  (oBUSY),
      .oERR   (oERR)
   );

   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   // ---------------- reference model ----------------
   function automatic string morse_of(input byte unsigned c);
      if (c >= 8'h41 && c <= 8'h5A) return morse_tab[c - 8'h41];
      if (c >= 8'h30 && c <= 8'h39) return morse_tab[26 + int'(c - 8'h30)];
      return "";
   endfunction

   // Expected {key,busy,err,ready} per cycle, from the first accept edge to the final idle cycle
   function automatic void build_expected(input string s);
      exp_q.delete();
      for (int i = 0; i < s.len(); i++) begin
         byte unsigned c;
         string        code;
         c = s[i];
         if (c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
         if (c == 8'h20) begin
            for (int k = 0; k < 4 * U; k++) exp_q.push_back(4'b0100);
         end else begin
            code = morse_of(c);
            if (code.len() == 0) begin
               exp_q.push_back(4'b0010);
            end else begin
               for (int e = 0; e < code.len(); e++) begin
                  for (int k = 0; k < ((code[e] == 8'h2D) ? 3 : 1) * U; k++)
                     exp_q.push_back(4'b1100);
                  if (e < code.len() - 1)
                     for (int k = 0; k < U; k++) exp_q.push_back(4'b0100);
               end
               for (int k = 0; k < 3 * U; k++) exp_q.push_back(4'b0100);
            end
         end
         exp_q.push_back(4'b0001);
      end
   endfunction

   // Stream a string with iVALID held high, recording outputs each cycle
   task automatic run_stream(input string s);
      int   idx;
      int   guard;
      logic acc;
      obs.delete();
      idx   = 0;
      guard = 0;
      while (oREADY !== 1'b1 && guard < 100) begin
         @(posedge iCLK); #1;
         guard++;
      end
      iCHAR  = s[0];
      iVALID = 1'b1;
      guard  = 0;
      forever begin
         acc = (oREADY === 1'b1) && iVALID;
         @(posedge iCLK); #1;
         if (acc) begin
            idx++;
            if (idx < s.len()) iCHAR = s[idx];
            else               iVALID = 1'b0;
         end
         obs.push_back({oKEY, oBUSY, oERR, oREADY});
         guard++;
         if ((idx == s.len() && oREADY === 1'b1) || guard > 5000) break;
      end
      iVALID = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      iRST_N = 1'b0;
      iVALID = 1'b0;
      iCHAR  = 8'h00;
      repeat (3) @(posedge iCLK);
      #1;
      compared++;
      if ({oKEY, oBUSY, oERR, oREADY} !== 4'b0000) begin
         mismatched++;
         $display("FAIL reset_hold: {key,busy,err,ready} got %b expected 0000", {oKEY, oBUSY, oERR, oREADY});
      end
      @(negedge iCLK);
      iRST_N = 1'b1;
      @(posedge iCLK); #1;
      compared++;
      if ({oKEY, oBUSY, oERR, oREADY} !== 4'b0001) begin
         mismatched++;
         $display("FAIL reset_release: {key,busy,err,ready} got %b expected 0001", {oKEY, oBUSY, oERR, oREADY});
      end
   endtask

   task automatic test_letters();
      logic [3:0] lower_obs[$];
      logic       same;
      run_stream("E");
      build_expected("E");
      compared++;
      if (obs.size() != exp_q.size()) begin
         mismatched++;
         $display("FAIL E_length: got %0d cycles expected %0d", obs.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         compared++;
         if (obs[i] !== exp_q[i]) begin
            mismatched++;
            $display("FAIL E_cycle%0d: {key,busy,err,ready} got %b expected %b", i, obs[i], exp_q[i]);
         end
      end
      run_stream("a");
      lower_obs = obs;
      build_expected("a");
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         compared++;
         if (obs[i] !== exp_q[i]) begin
            mismatched++;
            $display("FAIL a_cycle%0d: {key,busy,err,ready} got %b expected %b", i, obs[i], exp_q[i]);
         end
      end
      run_stream("A");
      same = (lower_obs.size() == obs.size());
      for (int i = 0; i < obs.size() && i < lower_obs.size(); i++)
         if (obs[i] !== lower_obs[i]) same = 1'b0;
      compared++;
      if (!same) begin
         mismatched++;
         $display("FAIL a_vs_A: lower/upper waveforms differ (%0d vs %0d cycles) expected identical", lower_obs.size(), obs.size());
      end
   endtask

   task automatic test_sos();
      run_stream("SOS");
      build_expected("SOS");
      compared++;
      if (obs.size() != exp_q.size()) begin
         mismatched++;
         $display("FAIL SOS_length: got %0d cycles expected %0d", obs.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         compared++;
         if (obs[i] !== exp_q[i]) begin
            mismatched++;
            $display("FAIL SOS_cycle%0d: {key,busy,err,ready} got %b expected %b", i, obs[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_bad_char();
      run_stream("#");
      build_expected("#");
      compared++;
      if (obs.size() != exp_q.size()) begin
         mismatched++;
         $display("FAIL bad_length: got %0d cycles expected %0d", obs.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         compared++;
         if (obs[i] !== exp_q[i]) begin
            mismatched++;
            $display("FAIL bad_cycle%0d: {key,busy,err,ready} got %b expected %b", i, obs[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_word_space();
      int first_end;
      int next_rise;
      // character gap, one idle cycle, word gap, one idle cycle
      int gap_exp = 3 * U + 1 + 4 * U + 1;
      run_stream("E E");
      build_expected("E E");
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         compared++;
         if (obs[i] !== exp_q[i]) begin
            mismatched++;
            $display("FAIL EspE_cycle%0d: {key,busy,err,ready} got %b expected %b", i, obs[i], exp_q[i]);
         end
      end
      first_end = -1;
      next_rise = -1;
      for (int i = 0; i < obs.size(); i++) begin
         if (obs[i][3] === 1'b1 && first_end == i - 1) first_end = i;
         else if (obs[i][3] === 1'b1 && next_rise < 0 && first_end >= 0) next_rise = i;
      end
      compared++;
      if (next_rise - first_end - 1 != gap_exp) begin
         mismatched++;
         $display("FAIL EspE_gap: key-low run got %0d cycles expected %0d", next_rise - first_end - 1, gap_exp);
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 6; t++) begin
         string s;
         int    n;
         s = "";
         n = $urandom_range(1, 4);
         for (int k = 0; k < n; k++) begin
            string        tmp;
            byte unsigned b;
            case ($urandom_range(0, 4))
               0:       b = 8'($urandom_range(8'h41, 8'h5A));
               1:       b = 8'($urandom_range(8'h61, 8'h7A));
               2:       b = 8'($urandom_range(8'h30, 8'h39));
               3:       b = 8'h20;
               default: b = 8'($urandom_range(1, 255));
            endcase
            tmp = "?";
            tmp.putc(0, b);
            s = {s, tmp};
         end
         run_stream(s);
         build_expected(s);
         compared++;
         if (obs.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL rand%0d_length: got %0d cycles expected %0d", t, obs.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            compared++;
            if (obs[i] !== exp_q[i]) begin
               mismatched++;
               $display("FAIL rand%0d_cycle%0d: {key,busy,err,ready} got %b expected %b", t, i, obs[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_dash();
      int guard;
      guard = 0;
      while (oREADY !== 1'b1 && guard < 100) begin
         @(posedge iCLK); #1;
         guard++;
      end
      iCHAR  = 8'h30;
      iVALID = 1'b1;
      @(posedge iCLK); #1;
      iVALID = 1'b0;
      repeat (5) @(posedge iCLK);
      #1;
      compared++;
      if (oKEY !== 1'b1) begin
         mismatched++;
         $display("FAIL mid_dash_key: got %b expected 1", oKEY);
      end
      #2;
      iRST_N = 1'b0;
      #1;
      compared++;
      if ({oKEY, oBUSY, oERR, oREADY} !== 4'b0000) begin
         mismatched++;
         $display("FAIL async_reset: {key,busy,err,ready} got %b expected 0000", {oKEY, oBUSY, oERR, oREADY});
      end
      repeat (2) @(posedge iCLK);
      @(negedge iCLK);
      iRST_N = 1'b1;
      @(posedge iCLK); #1;
      compared++;
      if ({oKEY, oBUSY, oERR, oREADY} !== 4'b0001) begin
         mismatched++;
         $display("FAIL post_reset_ready: {key,busy,err,ready} got %b expected 0001", {oKEY, oBUSY, oERR, oREADY});
      end
      run_stream("E");
      build_expected("E");
      compared++;
      if (obs.size() != exp_q.size()) begin
         mismatched++;
         $display("FAIL post_reset_E_length: got %0d cycles expected %0d", obs.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         compared++;
         if (obs[i] !== exp_q[i]) begin
            mismatched++;
            $display("FAIL post_reset_E_cycle%0d: {key,busy,err,ready} got %b expected %b", i, obs[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_letters();
      test_sos();
      test_bad_char();
      test_word_space();
      test_random();
      test_reset_mid_dash();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t expected to have finished", $time);
      $fatal(1);
   end

endmodule
`default_nettype wire
